// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch controller: owns the PC, strobes the
// instruction ROM, waits out the ROM latency, loads the IR and holds it until
// the consumer accepts it. Handles run/stop, stalls, redirects and halt.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | not fetching, waiting for run
// ISSUE   | rom_en high, ROM address (= pc) presented for one cycle
// WAIT    | ROM latency elapsing (ROM_LATENCY-1 cycles)
// CAPTURE | rom_data valid, loaded into ir at the end of the cycle
// VALID   | ir presented to the decoder until accepted (stall low)
// HALT    | halt instruction retired; only reset leaves this state
module fetch_sequencer #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       ROM_LATENCY = 1,
  parameter logic [31:0]       HALT_INSTR  = 32'h00000073
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic [31:0]       rom_data,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       ir,
  output logic              instr_valid,
  output logic              halted,
  output logic [15:0]       retired_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_VALID   = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  // Latency 1..4 means at most 3 cycles left to count after the issue cycle.
  localparam logic [1:0] LAT_LOAD = 2'(ROM_LATENCY - 1);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [1:0]        lat_cnt;
  logic [ADDR_W-1:0] target_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              retire;
  logic              redirect_taken;

  assign target_pc      = {redirect_target[ADDR_W-1:2], 2'b00};
  assign pc_inc         = pc + ADDR_W'(4);
  assign retire         = (state == S_VALID) && !stall;
  assign redirect_taken = redirect && ((state == S_ISSUE) || (state == S_WAIT) ||
                                       (state == S_CAPTURE) || (state == S_VALID));

  assign rom_en      = (state == S_ISSUE);
  assign rom_addr    = pc;
  assign instr_valid = (state == S_VALID);
  assign halted      = (state == S_HALT);

  // Next-state decode; a redirect restarts the fetch unless a halt retires.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (run) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (redirect)              state_nxt = S_ISSUE;
        else if (ROM_LATENCY == 1) state_nxt = S_CAPTURE;
        else                       state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect)              state_nxt = S_ISSUE;
        else if (lat_cnt == 2'd1)  state_nxt = S_CAPTURE;
      end
      S_CAPTURE: state_nxt = redirect ? S_ISSUE : S_VALID;
      S_VALID: begin
        if (retire) begin
          if (ir == HALT_INSTR)      state_nxt = S_HALT;
          else if (redirect || run)  state_nxt = S_ISSUE;
          else                       state_nxt = S_IDLE;
        end else if (redirect) begin
          state_nxt = S_ISSUE;
        end
      end
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ROM latency down-counter: loaded on issue, counts down through WAIT.
  always_ff @(posedge clk) begin
    if (!reset)                lat_cnt <= '0;
    else if (state == S_ISSUE) lat_cnt <= LAT_LOAD;
    else if (state == S_WAIT)  lat_cnt <= lat_cnt - 2'd1;
  end

  // Program counter: a redirect target replaces pc+4 even on a retiring cycle.
  always_ff @(posedge clk) begin
    if (!reset)              pc <= RESET_PC;
    else if (redirect_taken) pc <= target_pc;
    else if (retire)         pc <= pc_inc;
  end

  // Instruction register; data in flight during a redirect is dropped.
  always_ff @(posedge clk) begin
    if (!reset)                                ir <= '0;
    else if ((state == S_CAPTURE) && !redirect) ir <= rom_data;
  end

  // Retirement counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!reset)      retired_count <= '0;
    else if (retire) retired_count <= retired_count + 16'd1;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (latency 1 from PC 0, latency 3
// from PC 0xFFFFFFFC) share one stimulus stream. A behavioural model predicts
// every retirement into a queue; a monitor pops and compares on each DUT
// retirement, and also compares the visible outputs every cycle.
module tb_fetch_sequencer;

  localparam int          LAT_A = 1;
  localparam int          LAT_B = 3;
  localparam logic [31:0] RPC_A = 32'h0000_0000;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFFC;
  localparam logic [31:0] HALT  = 32'h0000_0073;

  localparam int M_IDLE = 0, M_FETCH = 1, M_HOLD = 2, M_HALT = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [15:0] cnt;
  } ret_t;

  logic        clk = 1'b0;
  logic        reset, run, stall, redirect;
  logic [31:0] redirect_target;

  logic        d_rom_en   [2];
  logic [31:0] d_rom_addr [2];
  logic [31:0] d_pc       [2];
  logic [31:0] d_ir       [2];
  logic        d_iv       [2];
  logic        d_halt     [2];
  logic [15:0] d_cnt      [2];
  logic [31:0] d_rom_data [2];

  logic [31:0] mem [64];
  logic        dl_v [2][4];
  logic [31:0] dl_a [2][4];
  logic [31:0] junk;

  int          m_mode [2];
  int          m_age  [2];
  logic [31:0] m_pc   [2];
  logic [31:0] m_ir   [2];
  logic [15:0] m_cnt  [2];
  ret_t        q0 [$];
  ret_t        q1 [$];

  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(32), .RESET_PC(RPC_A), .ROM_LATENCY(LAT_A), .HALT_INSTR(HALT)) dut_a (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .rom_data(d_rom_data[0]),
    .rom_en(d_rom_en[0]), .rom_addr(d_rom_addr[0]), .pc(d_pc[0]), .ir(d_ir[0]),
    .instr_valid(d_iv[0]), .halted(d_halt[0]), .retired_count(d_cnt[0]));

  fetch_sequencer #(.ADDR_W(32), .RESET_PC(RPC_B), .ROM_LATENCY(LAT_B), .HALT_INSTR(HALT)) dut_b (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .rom_data(d_rom_data[1]),
    .rom_en(d_rom_en[1]), .rom_addr(d_rom_addr[1]), .pc(d_pc[1]), .ir(d_ir[1]),
    .instr_valid(d_iv[1]), .halted(d_halt[1]), .retired_count(d_cnt[1]));

  // ROM with true latency: data is only valid exactly LAT cycles after a strobe.
  always @(posedge clk) begin
    junk <= $urandom;
    for (int k = 0; k < 2; k++) begin
      dl_v[k][0] <= d_rom_en[k];
      dl_a[k][0] <= d_rom_addr[k];
      for (int i = 1; i < 4; i++) begin
        dl_v[k][i] <= dl_v[k][i-1];
        dl_a[k][i] <= dl_a[k][i-1];
      end
    end
  end

  assign d_rom_data[0] = dl_v[0][LAT_A-1] ? mem[dl_a[0][LAT_A-1][7:2]] : junk;
  assign d_rom_data[1] = dl_v[1][LAT_B-1] ? mem[dl_a[1][LAT_B-1][7:2]] : junk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a fetch is "age" cycles old; it lands in ir at age LAT.
  task automatic model_step(input int k);
    int          lat;
    logic [31:0] rpc, tgt;
    ret_t        r;
    lat = (k == 0) ? LAT_A : LAT_B;
    rpc = (k == 0) ? RPC_A : RPC_B;
    tgt = redirect_target & 32'hFFFF_FFFC;
    if (!reset) begin
      m_mode[k] = M_IDLE; m_age[k] = 0; m_pc[k] = rpc; m_ir[k] = '0; m_cnt[k] = '0;
      return;
    end
    case (m_mode[k])
      M_IDLE: if (run) begin m_mode[k] = M_FETCH; m_age[k] = 0; end
      M_FETCH: begin
        if (redirect) begin
          m_pc[k] = tgt; m_age[k] = 0;
        end else if (m_age[k] == lat) begin
          m_ir[k] = mem[m_pc[k][7:2]]; m_mode[k] = M_HOLD;
        end else begin
          m_age[k] = m_age[k] + 1;
        end
      end
      M_HOLD: begin
        if (!stall) begin
          r.pc = m_pc[k]; r.ir = m_ir[k]; r.cnt = m_cnt[k];
          if (k == 0) q0.push_back(r); else q1.push_back(r);
          m_cnt[k] = m_cnt[k] + 16'd1;
          m_pc[k]  = redirect ? tgt : m_pc[k] + 32'd4;
          if (m_ir[k] == HALT)       m_mode[k] = M_HALT;
          else if (redirect || run) begin m_mode[k] = M_FETCH; m_age[k] = 0; end
          else                      m_mode[k] = M_IDLE;
        end else if (redirect) begin
          m_pc[k] = tgt; m_mode[k] = M_FETCH; m_age[k] = 0;
        end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // Monitor: per-cycle output compare, and retirement compare against the queue.
  logic        ret_seen [2];
  logic [79:0] ret_act  [2];
  ret_t        ret_exp;
  string       nm;

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        ret_seen[k] = 1'b0;
        if (mon_en) begin
          nm = (k == 0) ? "cycle_a" : "cycle_b";
          chk(nm, {d_rom_en[k], d_iv[k], d_halt[k], d_pc[k], d_rom_addr[k], d_ir[k], d_cnt[k]},
                  {(m_mode[k] == M_FETCH) && (m_age[k] == 0), m_mode[k] == M_HOLD,
                   m_mode[k] == M_HALT, m_pc[k], m_pc[k], m_ir[k], m_cnt[k]});
          ret_seen[k] = d_iv[k] && !stall && reset;
          ret_act[k]  = {d_pc[k], d_ir[k], d_cnt[k]};
        end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (ret_seen[k]) begin
          nm = (k == 0) ? "retire_a" : "retire_b";
          if (k == 0) begin
            chk({nm, "_pending"}, 128'(q0.size() != 0), 128'd1);
            if (q0.size() != 0) begin ret_exp = q0.pop_front(); chk(nm, ret_act[k], ret_exp); end
          end else begin
            chk({nm, "_pending"}, 128'(q1.size() != 0), 128'd1);
            if (q1.size() != 0) begin ret_exp = q1.pop_front(); chk(nm, ret_act[k], ret_exp); end
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      do w = $urandom; while (w == HALT);
      mem[i] = w;
    end
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    mem[3] = HALT;

    reset = 1'b0; run = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    tick(3);
    mon_en = 1'b1;
    reset  = 1'b1;
    tick();
    @(negedge clk);
    chk("reset_pc_a",  d_pc[0], 32'h0);
    chk("reset_pc_b",  d_pc[1], 32'hFFFF_FFFC);
    chk("reset_ir_a",  d_ir[0], 32'h0);
    chk("reset_out_a", {d_iv[0], d_rom_en[0], d_halt[0], d_cnt[0]}, 19'h0);

    // Basic fetch at latency 1: ISSUE, CAPTURE, VALID.
    run = 1'b1;
    tick(3);
    @(negedge clk);
    chk("first_valid_a", {d_iv[0], d_ir[0], d_pc[0]}, {1'b1, 32'h0050_0093, 32'h0});
    tick(3);
    @(negedge clk);
    chk("second_valid_a", {d_iv[0], d_ir[0], d_pc[0], d_cnt[0]}, {1'b1, 32'h00A0_0113, 32'h4, 16'd1});
    tick();
    @(negedge clk);
    chk("count_two_a", d_cnt[0], 16'd2);

    // Both instances reach the halt word at 0xC; B first retires 0xFFFFFFFC (pc wraps to 0).
    tick(40);
    @(negedge clk);
    chk("halt_a", {d_halt[0], d_pc[0], d_cnt[0]}, {1'b1, 32'h10, 16'd4});
    chk("halt_b", {d_halt[1], d_pc[1], d_cnt[1]}, {1'b1, 32'h10, 16'd5});
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom); stall = 1'($urandom); redirect = 1'($urandom);
      redirect_target = $urandom_range(0, 255);
      tick();
    end
    redirect = 1'b0; stall = 1'b0; run = 1'b0;
    @(negedge clk);
    chk("halt_held_a", {d_halt[0], d_pc[0], d_cnt[0]}, {1'b1, 32'h10, 16'd4});

    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("halt_reset_a", {d_halt[0], d_iv[0], d_pc[0]}, {1'b0, 1'b0, 32'h0});

    // Redirect in the CAPTURE cycle of address 8 (A is in CAPTURE 8 ticks after run).
    run = 1'b1;
    tick(8);
    @(negedge clk);
    chk("capture_pc_a", {d_pc[0], d_iv[0], d_rom_en[0]}, {32'h8, 1'b0, 1'b0});
    redirect = 1'b1; redirect_target = 32'h41;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("redirect_issue_a", {d_rom_en[0], d_rom_addr[0]}, {1'b1, 32'h40});

    // Randomised traffic: stalls, redirects, run drops and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      reset           = ($urandom_range(0, 99) >= 2);
      run             = ($urandom_range(0, 9) != 0);
      stall           = ($urandom_range(0, 9) < 3);
      redirect        = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom_range(0, 255);
      tick();
    end
    reset = 1'b1; run = 1'b0; stall = 1'b0; redirect = 1'b0;
    tick(2);
    chk("drained_a", 128'(q0.size()), 128'd0);
    chk("drained_b", 128'(q1.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle instruction-fetch controller that owns the program counter, drives the instruction ROM and loads the instruction register (IR) that feeds the instruction decoder. It replaces the free-running PC/PC+4 loop with a sequenced loop: issue, wait for ROM latency, capture, hold for the consumer. It also handles run/stop, stalls, branch redirects and halt-on-instruction.

Parameters:
ADDR_W, 32, width of PC and ROM address.
RESET_PC, 0, PC value loaded on reset.
ROM_LATENCY, 1, cycles from the ROM address issue to valid rom_data; legal range 1..4.
HALT_INSTR, 32'h00000073, IR value that sends the block to HALT when it retires.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low reset.
run  in  1  level enable; 1 starts or continues fetching.
stall  in  1  consumer not ready; holds the current IR.
redirect  in  1  branch/jump taken, one-cycle pulse.
redirect_target  in  ADDR_W  new PC for a redirect.
rom_data  in  32  ROM read data.
rom_en  out  1  ROM read strobe.
rom_addr  out  ADDR_W  ROM address; always equals pc.
pc  out  ADDR_W  address of the instruction in IR or currently being fetched.
ir  out  32  instruction register to the decoder.
instr_valid  out  1  ir holds a live instruction.
halted  out  1  block is in HALT.
retired_count  out  16  count of instructions accepted by the consumer.

Behaviour:
- Reset: reset==0 sampled at posedge -> state IDLE, pc=RESET_PC, ir=0, retired_count=0, latency counter=0, rom_en=0, instr_valid=0, halted=0. Reset overrides everything, including during HALT and mid-fetch.
- States: IDLE, ISSUE, WAIT, CAPTURE, VALID, HALT.
- IDLE: all strobes 0.
  - run=1 -> ISSUE.
- ISSUE (1 cycle): rom_en=1.
  - Latency counter loads ROM_LATENCY-1.
  - Next state is CAPTURE if ROM_LATENCY==1, else WAIT.
- WAIT: counter decrements each cycle.
  - When it reaches 1 -> CAPTURE.
  - This gives ROM_LATENCY-1 WAIT cycles in total.
- CAPTURE (1 cycle): ir <= rom_data at the end of the cycle. Next state VALID.
- VALID: instr_valid=1; ir and pc stay stable while stall=1. With stall=0 the instruction retires:
  - retired_count += 1, wrapping mod 2^16.
  - pc <= pc+4, wrapping mod 2^ADDR_W.
  - Next state HALT if ir==HALT_INSTR, else ISSUE if run=1, else IDLE.
- Cycles per instruction with no stall = ROM_LATENCY+2.
- HALT: halted=1, instr_valid=0, rom_en=0. pc holds the address of the halt instruction plus 4. run, stall and redirect are ignored; only reset exits HALT.
- run deasserted mid-fetch (ISSUE, WAIT or CAPTURE): the fetch completes to VALID and retires normally, then the block goes to IDLE.
- Redirect: sampled in ISSUE, WAIT, CAPTURE and VALID; ignored in IDLE and HALT.
  - pc <= {redirect_target[ADDR_W-1:2], 2'b00}.
  - Next state is ISSUE, regardless of run.
  - In-flight ROM data is discarded and ir is not updated that cycle.
- Redirect in VALID with stall=0: the current instruction retires (count +1) and the target replaces pc+4. A HALT_INSTR in ir still wins, going to HALT with pc = the redirect target.
- Redirect in VALID with stall=1: the current instruction is flushed, with no count, and instr_valid drops in the next cycle.
- instr_valid is 1 only in VALID. rom_en is 1 only in ISSUE.

Test Plan:
- Basic fetch, ROM_LATENCY=1: release reset, run=1, ROM[0]=0x00500093, ROM[4]=0x00A00113. Required: instr_valid high 3 cycles after the run edge with ir=0x00500093, pc=0. Three cycles later ir=0x00A00113, pc=4. retired_count=2 after the second VALID cycle.
- Latency and stall, ROM_LATENCY=3: one instruction takes 5 cycles. Hold stall=1 for 4 VALID cycles: ir, pc and count stay frozen. On stall release the count increments by exactly 1.
- Redirect: in the CAPTURE cycle of addr 0x8, pulse redirect with target 0x41 -> the next ISSUE drives rom_addr=0x40 and ir never shows ROM[8]. Redirect during VALID with stall=1 -> count unchanged.
- Halt: ROM[0xC]=0x00000073 -> after it retires, halted=1, pc=0x10, count=4, rom_en stays 0 for 20 cycles. Then reset low for 1 cycle -> IDLE, pc=0, halted=0.
- Stop and wrap: drop run in WAIT -> the instruction still retires, then IDLE with rom_en=0.
  - RESET_PC=0xFFFFFFFC: after the first retire, pc=0x00000000.
  - Preload 0xFFFF retirements: the next retire gives retired_count=0.
- Reset mid-fetch: reset=0 during WAIT -> the next cycle shows IDLE outputs with ir=0 and count=0, and no spurious instr_valid.
